trace_packer: RTL and testbench
===============================

Name: trace_packer

Overview:
- Sits downstream of the trace filter and consumes its pc_valid/instr/drop_instr stream.
- Each kept instruction (branch/jump/WFI or the one after it) becomes one packet: {gap, instr, pc}.
- gap = number of dropped instructions since the previous kept one.
- Packets are buffered in a small FIFO and drained over a valid/ready stream toward the DMA/host path.

Parameters:
- PC_WIDTH, 64, width of the program counter field.
- GAP_WIDTH, 16, width of the saturating dropped-instruction counter.
- FIFO_DEPTH, 8, packet buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  capture enable; when low, input beats are ignored and gap is held.
- pc_valid  in  1  input beat strobe, same meaning as the trace filter's input.
- pc  in  PC_WIDTH  program counter of the beat.
- instr  in  RISC_V_INSTRUCTION_WIDTH  instruction of the beat.
- drop_instr  in  1  1 = beat filtered out, 0 = beat kept.
- m_tvalid  out  1  packet available.
- m_tready  in  1  consumer accepts the packet.
- m_tdata  out  PC_WIDTH+32+GAP_WIDTH  packet. Bits [GAP_WIDTH-1:0] = gap; next 32 bits = instr; top PC_WIDTH bits = pc.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a kept packet was lost.
- overflow_clr  in  1  single-cycle clear of overflow.

Behaviour:
- Reset (async assert, sync release): FIFO emptied, gap=0, overflow=0, m_tvalid=0, fifo_level=0, m_tdata=0.
- Input beat = pc_valid && en. With en=0, no state changes except the output pop and overflow_clr.
- Dropped beat (drop_instr=1): gap <= gap+1, saturating at 2^GAP_WIDTH-1. No push.
- Kept beat (drop_instr=0) with space: push {gap, instr, pc} and set gap <= 0.
  - The pushed gap is the pre-beat value.
- Space rule: push allowed if level<FIFO_DEPTH, or if a pop occurs in the same cycle (pop before push). A full FIFO with m_tready=1 still accepts and reports no overflow.
- Kept beat with no space: packet discarded, overflow <= 1, and gap <= sat(gap+1).
  - The lost instruction is counted in the next packet's gap.
- Pop: m_tvalid && m_tready. The head advances and fifo_level decrements.
  - Simultaneous push and pop leaves the level unchanged.
- m_tvalid = (level != 0). m_tdata = head entry, stable while m_tvalid && !m_tready (AXI-Stream rules).
- Latency: a kept beat in cycle N into an empty FIFO gives m_tvalid=1 in cycle N+1.
- overflow_clr and a new overflow in the same cycle: set wins.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Reset asserted mid-stream: all buffered packets are lost and the next packet reports gap=0. No partial packet is emitted.

Decomposition:
- continuous_monitoring_system_pkg gains:
  - typedef trace_packet_t, a packed struct {pc, instr, gap} using the PC_WIDTH/GAP_WIDTH defaults;
  - constants TRACE_PACKET_WIDTH and TRACE_GAP_MAX.
- The existing RISC_V_INSTRUCTION_WIDTH constant is reused.
- One sub-module, trace_packer_fifo:
  - parameterised synchronous FIFO (width, depth) with push/pop/level/full/empty;
  - same clk/rst convention.
- Gap counter, overflow logic and stream interface live in the top module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> m_tvalid=0, fifo_level=0, overflow=0 immediately.
- Gap count, m_tready=1:
  - stimulus: kept pc=0x80000000 instr=0x0000006F; then 3 dropped beats; then kept pc=0x80000010 instr=0x00008067;
  - response: packets {gap=0, 0x0000006F, 0x80000000} then {gap=3, 0x00008067, 0x80000010}; m_tvalid one cycle after each kept beat.
- Backpressure overflow:
  - stimulus: m_tready=0, 9 consecutive kept beats;
  - response: fifo_level=8, overflow=1, 9th packet absent.
  - Then drain 8 and send 1 kept beat -> its gap=1. Pulse overflow_clr -> overflow=0.
- Full with pop, FIFO full and m_tready=1: one kept beat -> accepted, level stays 8, overflow stays 0.
- Saturation, GAP_WIDTH=4: 20 dropped beats then 1 kept -> packet gap=15. The following kept beat -> gap=0.
- en gating: en=0 with 5 dropped and 2 kept beats -> no packets, gap unchanged. Re-enable, 1 kept -> gap equals the pre-disable value.

Source files
------------

// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and constants for the continuous monitoring trace path.
package continuous_monitoring_system_pkg;

  localparam int RISC_V_INSTRUCTION_WIDTH = 32;

  localparam int TRACE_PC_WIDTH_DEFAULT  = 64;
  localparam int TRACE_GAP_WIDTH_DEFAULT = 16;

  localparam int TRACE_PACKET_WIDTH =
    TRACE_PC_WIDTH_DEFAULT + RISC_V_INSTRUCTION_WIDTH + TRACE_GAP_WIDTH_DEFAULT;

  localparam logic [TRACE_GAP_WIDTH_DEFAULT-1:0] TRACE_GAP_MAX = '1;

  // pc occupies the top bits, gap the bottom bits
  typedef struct packed {
    logic [TRACE_PC_WIDTH_DEFAULT-1:0]   pc;
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
    logic [TRACE_GAP_WIDTH_DEFAULT-1:0]  gap;
  } trace_packet_t;

endpackage

// File: rtl/trace_packer_fifo.sv
// Synchronous FIFO with extra-bit pointers; push while full is taken only
// when a pop happens in the same cycle (the slot is freed by the pop).
module trace_packer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign empty     = (r_wr == r_rd);
  assign level     = r_wr - r_rd;
  assign rdata     = r_mem[r_rd[AW-1:0]];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  // Storage array: data only, never reset
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= wdata;
  end

  // Read/write pointers, wrapping modulo 2*DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + PTR_ONE;
      if (w_do_pop)  r_rd <= r_rd + PTR_ONE;
    end
  end

endmodule

// File: rtl/trace_packer.sv
// Packs kept trace beats into {pc, instr, gap} packets and streams them out
// through a small FIFO; gap counts beats dropped (or lost) since the last packet.
module trace_packer
  import continuous_monitoring_system_pkg::*;
#(
  parameter int PC_WIDTH   = 64,
  parameter int GAP_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          en,
  input  logic                                          pc_valid,
  input  logic [PC_WIDTH-1:0]                           pc,
  input  logic [RISC_V_INSTRUCTION_WIDTH-1:0]           instr,
  input  logic                                          drop_instr,
  output logic                                          m_tvalid,
  input  logic                                          m_tready,
  output logic [PC_WIDTH+RISC_V_INSTRUCTION_WIDTH+GAP_WIDTH-1:0] m_tdata,
  output logic [$clog2(FIFO_DEPTH):0]                   fifo_level,
  output logic                                          overflow,
  input  logic                                          overflow_clr
);

  localparam int PKT_W = PC_WIDTH + RISC_V_INSTRUCTION_WIDTH + GAP_WIDTH;
  localparam logic [GAP_WIDTH-1:0] GAP_ONE = {{(GAP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GAP_WIDTH-1:0] GAP_MAX = '1;

  function automatic logic [GAP_WIDTH-1:0] sat_inc(input logic [GAP_WIDTH-1:0] g);
    return (g == GAP_MAX) ? GAP_MAX : g + GAP_ONE;
  endfunction

  logic [GAP_WIDTH-1:0] r_gap;
  logic                 r_overflow;
  logic                 w_beat;
  logic                 w_pop;
  logic                 w_space;
  logic                 w_push;
  logic                 w_lost;
  logic                 w_full;
  logic                 w_empty;
  logic [PKT_W-1:0]     w_head;

  assign w_beat  = pc_valid && en;
  assign w_pop   = m_tvalid && m_tready;
  // A full FIFO still accepts when the head leaves in the same cycle
  assign w_space = !w_full || w_pop;
  assign w_push  = w_beat && !drop_instr && w_space;
  assign w_lost  = w_beat && !drop_instr && !w_space;

  trace_packer_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata ({pc, instr, r_gap}),
    .rdata (w_head),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

  assign m_tvalid = !w_empty;
  // Unwritten storage is never exposed: an empty FIFO presents zero
  assign m_tdata  = w_empty ? '0 : w_head;
  assign overflow = r_overflow;

  // Gap counter: dropped and lost beats count, a stored packet restarts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap <= '0;
    end else if (w_beat) begin
      if (drop_instr || w_lost) r_gap <= sat_inc(r_gap);
      else                      r_gap <= '0;
    end
  end

  // Sticky overflow flag; a new loss wins over a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_overflow <= 1'b0;
    else if (w_lost)       r_overflow <= 1'b1;
    else if (overflow_clr) r_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_trace_packer.sv
// Directed scoreboard bench for trace_packer (GAP_WIDTH=4 to reach saturation).
module tb_trace_packer;

  localparam int PCW = 64;
  localparam int IW  = 32;
  localparam int GW  = 4;
  localparam int DEP = 8;
  localparam int TW  = PCW + IW + GW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b1;
  logic            pc_valid = 1'b0;
  logic [PCW-1:0]  pc = '0;
  logic [IW-1:0]   instr = '0;
  logic            drop_instr = 1'b0;
  logic            m_tvalid;
  logic            m_tready = 1'b1;
  logic [TW-1:0]   m_tdata;
  logic [3:0]      fifo_level;
  logic            overflow;
  logic            overflow_clr = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [TW-1:0] exp_q [$];

  trace_packer #(
    .PC_WIDTH   (PCW),
    .GAP_WIDTH  (GW),
    .FIFO_DEPTH (DEP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .pc_valid     (pc_valid),
    .pc           (pc),
    .instr        (instr),
    .drop_instr   (drop_instr),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tdata      (m_tdata),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer completes at the next posedge when valid && ready now
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pkt_unexpected: got %0h expected none", m_tdata);
      end else begin
        chk("pkt", m_tdata, exp_q.pop_front());
      end
    end
  end

  // One input cycle; inputs change 2 time units after the clock edge
  task automatic step(input logic v, input logic d, input logic [PCW-1:0] p, input logic [IW-1:0] ins);
    pc_valid = v; drop_instr = d; pc = p; instr = ins;
    @(posedge clk); #2;
    pc_valid = 1'b0; drop_instr = 1'b0;
  endtask

  task automatic kept(input logic [PCW-1:0] p, input logic [IW-1:0] ins,
                      input logic [GW-1:0] g, input bit stored);
    if (stored) exp_q.push_back({p, ins, g});
    step(1'b1, 1'b0, p, ins);
  endtask

  task automatic dropped(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 64'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'h0, 32'h0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst_tvalid", TW'(m_tvalid), TW'(0));
    chk("rst_level", TW'(fifo_level), TW'(0));
    chk("rst_overflow", TW'(overflow), TW'(0));
    chk("rst_tdata", m_tdata, TW'(0));
    rst = 1'b0;

    // Gap counting with latency check
    m_tready = 1'b1;
    chk("lat_before", TW'(m_tvalid), TW'(0));
    kept(64'h8000_0000, 32'h0000_006F, 4'd0, 1'b1);
    chk("lat_after1", TW'(m_tvalid), TW'(1));
    dropped(3);
    chk("lat_gap_empty", TW'(m_tvalid), TW'(0));
    kept(64'h8000_0010, 32'h0000_8067, 4'd3, 1'b1);
    chk("lat_after2", TW'(m_tvalid), TW'(1));
    idle(3);

    // Backpressure overflow
    m_tready = 1'b0;
    for (int i = 0; i < 9; i++)
      kept(64'h1000 + 64'(i * 4), 32'h13, 4'd0, i < 8);
    chk("bp_level", TW'(fifo_level), TW'(8));
    chk("bp_overflow", TW'(overflow), TW'(1));
    chk("bp_head_stable", m_tdata, {64'h1000, 32'h13, 4'd0});
    m_tready = 1'b1;
    idle(8);
    chk("bp_drained", TW'(fifo_level), TW'(0));
    kept(64'h2000, 32'h0000_0063, 4'd1, 1'b1);
    idle(2);
    chk("bp_ovf_sticky", TW'(overflow), TW'(1));
    overflow_clr = 1'b1;
    idle(1);
    overflow_clr = 1'b0;
    chk("bp_ovf_clr", TW'(overflow), TW'(0));

    // Full FIFO with a simultaneous pop still accepts
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++)
      kept(64'h3000 + 64'(i * 4), 32'h6F, 4'd0, 1'b1);
    chk("full_level", TW'(fifo_level), TW'(8));
    m_tready = 1'b1;
    kept(64'h3100, 32'h0010_0073, 4'd0, 1'b1);
    chk("full_pop_level", TW'(fifo_level), TW'(8));
    chk("full_pop_ovf", TW'(overflow), TW'(0));
    idle(10);

    // Gap saturation
    dropped(20);
    kept(64'h4000, 32'h0000_0067, 4'd15, 1'b1);
    kept(64'h4004, 32'h0000_0067, 4'd0, 1'b1);
    idle(3);

    // en gating
    dropped(2);
    en = 1'b0;
    dropped(5);
    kept(64'h5000, 32'h6F, 4'd0, 1'b0);
    kept(64'h5004, 32'h6F, 4'd0, 1'b0);
    chk("en_level", TW'(fifo_level), TW'(0));
    chk("en_tvalid", TW'(m_tvalid), TW'(0));
    en = 1'b1;
    kept(64'h5008, 32'h0000_8067, 4'd2, 1'b1);
    idle(3);

    // Asynchronous reset mid-stream
    m_tready = 1'b0;
    dropped(1);
    for (int i = 0; i < 9; i++)
      kept(64'h6000 + 64'(i * 4), 32'h13, (i == 0) ? 4'd1 : 4'd0, i < 8);
    chk("ar_pre_ovf", TW'(overflow), TW'(1));
    #3;
    rst = 1'b1;
    #1;
    chk("ar_tvalid", TW'(m_tvalid), TW'(0));
    chk("ar_level", TW'(fifo_level), TW'(0));
    chk("ar_overflow", TW'(overflow), TW'(0));
    exp_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    m_tready = 1'b1;
    kept(64'h7000, 32'h0000_006F, 4'd0, 1'b1);

    // Drain with a bounded wait
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    chk("final_queue_empty", TW'(exp_q.size()), TW'(0));
    chk("final_level", TW'(fifo_level), TW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
